// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared FSM state type and digit constants for binary_to_bcd_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

  function automatic int bcd_digit_width();
    return 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module  : bcd_digit_adjust
// Brief   : Double-dabble per-digit correction: add 3 to any digit >= 5.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // 4-bit wrap is intended; the decimal carry travels with the next shift.
  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ) : digit_i;

endmodule

`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
// ============================================================================
// Module  : binary_to_bcd_seq
// Brief   : Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int DW    = bcd_digit_width();
  localparam int BCD_W = DW * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   shift_q;
  logic [BCD_W-1:0]   digits_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               overflow_q;

  logic [BCD_W-1:0]   digits_adj;
  logic [BCD_W-1:0]   digits_d;
  logic [WIDTH-1:0]   shift_d;
  logic               carry_out;
  logic               ovf_d;
  logic               last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (digits_q[DW*g +: DW]),
      .digit_o (digits_adj[DW*g +: DW])
    );
  end

  // Anything leaving the top digit means the value no longer fits in DIGITS.
  assign {carry_out, digits_d, shift_d} = {digits_adj, shift_q, 1'b0};
  assign ovf_d     = ovf_q | carry_out;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_q  <= bin;
            digits_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          digits_q <= digits_d;
          shift_q  <= shift_d;
          ovf_q    <= ovf_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            bcd_q      <= digits_d;
            overflow_q <= ovf_d;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
// ============================================================================
// Module  : tb_binary_to_bcd_seq
// Brief   : Directed and table-driven checks of binary_to_bcd_seq (3 and 2 digits).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy, done, overflow;
  logic [11:0] bcd;

  logic        start2 = 1'b0;
  logic [7:0]  bin2 = '0;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
  );

  typedef struct {
    logic [7:0]  b;
    logic [11:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Pulse start for one cycle, then count edges until done (bounded).
  task automatic conv(input logic [7:0] b, output logic [11:0] r, output logic o, output int lat);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bcd;
    o = overflow;
  endtask

  task automatic conv2(input logic [7:0] b, output logic [7:0] r, output logic o, output int lat);
    @(negedge clk);
    start2 = 1'b1;
    bin2   = b;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bcd2;
    o = overflow2;
  endtask

  initial begin
    vec_t        vecs [6];
    logic [11:0] r;
    logic [7:0]  r2;
    logic        o;
    int          lat;
    int          cyc;
    int          seen;
    int          d1, d2;
    logic [11:0] b1, b2;

    vecs[0] = '{8'd0,   12'h000, 1'b0};
    vecs[1] = '{8'd255, 12'h255, 1'b0};
    vecs[2] = '{8'd99,  12'h099, 1'b0};
    vecs[3] = '{8'd100, 12'h100, 1'b0};
    vecs[4] = '{8'd42,  12'h042, 1'b0};
    vecs[5] = '{8'd7,   12'h007, 1'b0};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bcd2", 32'(bcd2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors, including latency
    for (int i = 0; i < 6; i++) begin
      conv(vecs[i].b, r, o, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_bcd", i), 32'(r), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].exp_ovf));
    end

    // Exhaustive sweep against decimal reference
    for (int v = 0; v < 256; v++) begin
      conv(8'(v), r, o, lat);
      check($sformatf("sweep%0d_bcd", v), 32'(r), 32'(ref_bcd(v)));
      check($sformatf("sweep%0d_ovf", v), 32'(o), 32'd0);
    end

    // Two-digit instance overflow boundary
    conv2(8'd100, r2, o, lat);
    check("d2_100_ovf", 32'(o), 32'd1);
    check("d2_100_lat", 32'(lat), 32'd8);
    conv2(8'd99, r2, o, lat);
    check("d2_99_bcd", 32'(r2), 32'h99);
    check("d2_99_ovf", 32'(o), 32'd0);
    conv2(8'd255, r2, o, lat);
    check("d2_255_ovf", 32'(o), 32'd1);
    conv2(8'd9, r2, o, lat);
    check("d2_9_bcd", 32'(r2), 32'h09);
    check("d2_9_ovf", 32'(o), 32'd0);

    // start pulses while busy must be ignored
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd123;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (cyc == 2 || cyc == 4) begin
        start = 1'b1;
        bin   = 8'd77;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc < 8) check($sformatf("busy_c%0d", cyc), 32'(busy), 32'd1);
    end
    start = 1'b0;
    check("ign_lat", 32'(cyc), 32'd8);
    check("ign_bcd", 32'(bcd), 32'h123);
    @(posedge clk); #1;
    check("ign_idle_busy", 32'(busy), 32'd0);

    // Reset mid-SHIFT aborts with no done pulse
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("mid_no_done", 32'(seen), 32'd0);
    check("mid_bcd_hold", 32'(bcd), 32'd0);
    conv(8'd42, r, o, lat);
    check("post_rst_bcd", 32'(r), 32'h042);
    check("post_rst_lat", 32'(lat), 32'd8);

    // start held high: back-to-back conversions every WIDTH+1 cycles
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd17;
    @(posedge clk); #1;
    bin = 8'd200;
    cyc = 0; d1 = -1; d2 = -1; b1 = '0; b2 = '0;
    while (d2 < 0 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc; b1 = bcd;
        end else begin
          d2 = cyc; b2 = bcd;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_at", 32'(d1), 32'd8);
    check("b2b_first_bcd", 32'(b1), 32'h017);
    check("b2b_gap", 32'(d2 - d1), 32'd9);
    check("b2b_second_bcd", 32'(b2), 32'h200);
    @(posedge clk); #1;
    check("b2b_stop_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
